range_filter: RTL and testbench
===============================

// Module: range_filter
// PURPOSE
// - Downstream consumer of the ultrasonic ranger: takes each 12-bit distance sample (cm) and its one-cycle sync strobe.
// - Smooths the samples with a moving average over a 2^LOG2_DEPTH ring buffer.
// - Drives a proximity alarm with hysteresis. Sits between the ranger and the display/UART/debug logic.
// PARAMETERS
// - LOG2_DEPTH  2    window = 2^LOG2_DEPTH samples (1..5)
// - NEAR_CM     30   alarm asserts when avg < NEAR_CM
// - HYST_CM     5    alarm releases when avg >= NEAR_CM + HYST_CM
// - MAX_CM      400  largest plausible sample (used only with RANGE_FILTER_OUTLIER_EN)
// PORTS
// - clk          in   1   system clock, single clock domain
// - rst          in   1   synchronous reset, active-high
// - dist_in      in   12  distance sample, cm, unsigned
// - dist_valid   in   1   one-cycle strobe; dist_in valid this cycle (the ranger's synch)
// - flush        in   1   discard window, return to FILL
// - avg_out      out  12  windowed mean, cm
// - avg_valid    out  1   one-cycle strobe, avg_out updated
// - alarm        out  1   proximity alarm, level
// - filled       out  1   high in RUN state
// - reject_cnt   out  8   rejected-sample count, saturating (0 when macro off)
// BEHAVIOUR
// - Reset (sync, rst=1): avg_out=0, avg_valid=0, alarm=0, filled=0, reject_cnt=0, sum=0, wr_ptr=0, fill_cnt=0, state=FILL. Buffer RAM is not cleared.
// - FSM FILL: each accepted sample is written at wr_ptr; sum += sample; fill_cnt++; no avg_valid.
//   - When fill_cnt reaches 2^LOG2_DEPTH-1 and another sample is accepted, go to RUN.
//   - That cycle's result is the first average.
// - FSM RUN: oldest = buf[wr_ptr], read before the same-cycle write; sum <= sum - oldest + sample; buffer overwritten.
// - wr_ptr increments on every accepted sample and wraps modulo 2^LOG2_DEPTH.
// - Sum width: 12+LOG2_DEPTH bits, unsigned; never overflows. avg_out = sum >> LOG2_DEPTH (truncating).
// - Pipeline: stage 1 accepts, writes and updates sum; stage 2 registers avg_out and alarm and pulses avg_valid.
//   - avg_valid is high exactly 2 cycles after the accepted dist_valid.
//   - Throughput: 1 sample per cycle, including back-to-back strobes.
// - Alarm, evaluated on the new avg in stage 2:
//   - set when avg < NEAR_CM;
//   - clear when avg >= NEAR_CM+HYST_CM;
//   - otherwise hold. Alarm changes only with avg_valid.
// - flush: state=FILL, sum=0, fill_cnt=0, wr_ptr=0.
//   - alarm and avg_out hold their values; a stage-2 strobe already in flight is cancelled.
//   - flush together with dist_valid: flush wins, sample dropped.
// - Reset during operation behaves identically to the power-up reset. There is no partial state.
// - dist_valid without flush in FILL/RUN: never stalled, never dropped (except outlier rejection).
// CONFIGURATION
// - RANGE_FILTER_OUTLIER_EN defined:
//   - samples equal to 0 or > MAX_CM are rejected in stage 1;
//   - no buffer write, no sum/ptr change, no avg_valid;
//   - reject_cnt += 1, saturating at 255.
// - RANGE_FILTER_OUTLIER_EN undefined: every strobed sample is accepted; reject_cnt tied to 0.
// STRUCTURE
// - Package range_pkg: typedef logic [11:0] dist_cm_t; enum {FILL, RUN} rf_state_e; localparam DIST_W=12.
// - Sub-module range_ring_buf:
//   - 2^LOG2_DEPTH x 12 register array with wr_ptr;
//   - combinational read of oldest entry, synchronous write on accept.
// - Top (range_filter): FSM, sum, stage-2 registers, alarm hysteresis, outlier check.
// TESTING (LOG2_DEPTH=2, NEAR_CM=30, HYST_CM=5)
// - Fill window: strobe 100,200,300,400 (gaps of 3 cycles).
//   - No avg_valid for the first 3 samples.
//   - filled=1 and avg_out=250 2 cycles after the 4th.
// - Slide window: then 800 -> avg_out=425; then 4 back-to-back strobes of 0x00A -> 4 consecutive avg_valid, final avg_out=10.
// - Hysteresis:
//   - 4x20 -> alarm=1;
//   - 4x34 -> alarm stays 1 (avg 34);
//   - one 35 after window full of 35s -> alarm=0 exactly on that avg_valid.
// - Flush: assert flush together with the 2nd sample of a fill.
//   - That sample is dropped, filled=0.
//   - 4 new samples of 50 -> avg_out=50.
// - Reset mid-RUN: rst for 1 cycle with a sample in stage 2.
//   - No avg_valid.
//   - All outputs 0 next cycle.
//   - The following fill behaves as at power-up.
// - Macro on:
//   - samples 0 and 4000 -> reject_cnt=2, no avg_valid, window unchanged;
//   - 300 more rejects -> reject_cnt=255.

Source files
------------

// File: rtl/range_pkg.sv
// range_pkg: shared types and helpers for the range_filter slice.
//   DIST_W      distance sample width (cm)
//   dist_cm_t   distance sample type
//   rf_state_e  window FSM states (FILL while the window is filling, RUN once full)
//   sat_inc8    8-bit saturating increment
package range_pkg;

  localparam int DIST_W = 12;

  typedef logic [DIST_W-1:0] dist_cm_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/range_ring_buf.sv
// range_ring_buf: 2^LOG2_DEPTH x DIST_W sample ring buffer with its own write pointer.
//   clk     system clock
//   rst     synchronous active-high reset (pointer only; storage is not cleared)
//   clr     return the write pointer to 0 (window discard)
//   we      write wdata at the write pointer and advance it
//   wdata   sample to store
//   oldest  entry at the write pointer, i.e. the sample about to be overwritten;
//           combinational, so it reflects the contents before this cycle's write
module range_ring_buf
  import range_pkg::*;
#(
  parameter int LOG2_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [DIST_W-1:0] wdata,
  output logic [DIST_W-1:0] oldest
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DIST_W-1:0]     mem_q [DEPTH];
  logic [DIST_W-1:0]     mem_d [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
    end else if (we) begin
      mem_d[wr_ptr_q] = wdata;
      // pointer width equals LOG2_DEPTH, so the increment wraps modulo the depth
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign oldest = mem_q[wr_ptr_q];

endmodule

// File: rtl/range_filter.sv
// range_filter: moving-average smoother and proximity alarm for ranger samples.
//   Parameters: LOG2_DEPTH (window = 2^LOG2_DEPTH), NEAR_CM (alarm set below),
//               HYST_CM (release at NEAR_CM+HYST_CM or above), MAX_CM (outlier limit).
//   Optional feature macro: RANGE_FILTER_OUTLIER_EN rejects samples equal to 0 or
//   above MAX_CM and counts them in reject_cnt; without it reject_cnt stays 0.
//   Ports:
//     clk         system clock
//     rst         synchronous active-high reset
//     dist_in     12-bit distance sample (cm)
//     dist_valid  one-cycle sample strobe
//     flush       discard window and return to FILL (wins over dist_valid)
//     avg_out     windowed mean (cm), held between updates
//     avg_valid   one-cycle strobe, two cycles after the accepted sample
//     alarm       proximity alarm with hysteresis
//     filled      high while the window is full (RUN)
//     reject_cnt  saturating count of rejected samples
module range_filter
  import range_pkg::*;
#(
  parameter int LOG2_DEPTH = 2,
  parameter int NEAR_CM    = 30,
  parameter int HYST_CM    = 5,
  parameter int MAX_CM     = 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_valid,
  input  logic              flush,
  output logic [DIST_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              alarm,
  output logic              filled,
  output logic [7:0]        reject_cnt
);

  localparam int                    SUM_W    = DIST_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] FULL_CNT = '1;
  localparam dist_cm_t              NEAR_V   = dist_cm_t'(NEAR_CM);
  localparam dist_cm_t              CLR_V    = dist_cm_t'(NEAR_CM + HYST_CM);
  localparam dist_cm_t              MAX_V    = dist_cm_t'(MAX_CM);

`ifdef RANGE_FILTER_OUTLIER_EN
  localparam bit OUTLIER_EN = 1'b1;
`else
  localparam bit OUTLIER_EN = 1'b0;
`endif

  rf_state_e             state_q, state_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [LOG2_DEPTH-1:0] fill_cnt_q, fill_cnt_d;
  logic                  s1_valid_q, s1_valid_d;
  dist_cm_t              avg_q, avg_d;
  logic                  avg_valid_q, avg_valid_d;
  logic                  alarm_q, alarm_d;
  logic [7:0]            rej_q, rej_d;

  logic                  take;
  logic                  outlier;
  logic                  accept;
  logic                  last_fill;
  dist_cm_t              oldest;
  dist_cm_t              new_avg;

  assign take      = dist_valid && !flush;
  assign outlier   = OUTLIER_EN && ((dist_in == '0) || (dist_in > MAX_V));
  assign accept    = take && !outlier;
  assign last_fill = (state_q == FILL) && (fill_cnt_q == FULL_CNT);
  assign new_avg   = sum_q[SUM_W-1:LOG2_DEPTH];

  range_ring_buf #(
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .we    (accept),
    .wdata (dist_in),
    .oldest(oldest)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FILL;
    end else if (accept && last_fill) begin
      state_d = RUN;
    end
  end

  // FSM: outputs
  always_comb begin
    filled = (state_q == RUN);
  end

  // Stage 1 (sum / fill count / reject count) and stage 2 (average / alarm)
  always_comb begin
    sum_d       = sum_q;
    fill_cnt_d  = fill_cnt_q;
    s1_valid_d  = 1'b0;
    rej_d       = rej_q;
    avg_d       = avg_q;
    alarm_d     = alarm_q;

    if (flush) begin
      sum_d      = '0;
      fill_cnt_d = '0;
    end else if (accept) begin
      if (state_q == RUN) begin
        // sum always contains oldest, so the subtraction cannot underflow
        sum_d      = sum_q - SUM_W'(oldest) + SUM_W'(dist_in);
        s1_valid_d = 1'b1;
      end else begin
        sum_d      = sum_q + SUM_W'(dist_in);
        fill_cnt_d = fill_cnt_q + 1'b1;
        s1_valid_d = last_fill;
      end
    end

    if (take && outlier) begin
      rej_d = sat_inc8(rej_q);
    end

    // a flush cancels the strobe in flight; avg and alarm keep their values
    avg_valid_d = s1_valid_q && !flush;
    if (avg_valid_d) begin
      avg_d = new_avg;
      if (new_avg < NEAR_V) begin
        alarm_d = 1'b1;
      end else if (new_avg >= CLR_V) begin
        alarm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      fill_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      rej_q       <= '0;
    end else begin
      sum_q       <= sum_d;
      fill_cnt_q  <= fill_cnt_d;
      s1_valid_q  <= s1_valid_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      alarm_q     <= alarm_d;
      rej_q       <= rej_d;
    end
  end

  assign avg_out    = avg_q;
  assign avg_valid  = avg_valid_q;
  assign alarm      = alarm_q;
  assign reject_cnt = rej_q;

endmodule

// File: tb/tb_range_filter.sv
module tb_range_filter;

  localparam int DEPTH = 4;
  localparam int NEAR  = 30;
  localparam int CLR   = 35;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] dist_in;
  logic        dist_valid;
  logic        flush;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        alarm;
  logic        filled;
  logic [7:0]  reject_cnt;

  range_filter #(
    .LOG2_DEPTH(2),
    .NEAR_CM   (30),
    .HYST_CM   (5),
    .MAX_CM    (400)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dist_in   (dist_in),
    .dist_valid(dist_valid),
    .flush     (flush),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .alarm     (alarm),
    .filled    (filled),
    .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int avg;
    bit alm;
    int cyc;
  } exp_t;

  exp_t expq[$];
  int   win[$];
  bit   alarm_m = 1'b0;
  int   rej_m   = 0;
  int   cyc     = 0;
  int   checks  = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic bit is_outlier(input int v);
`ifdef RANGE_FILTER_OUTLIER_EN
    return (v == 0) || (v > 400);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: window kept as a queue of the last DEPTH accepted samples
  function automatic void model_accept(input int v);
    int s;
    int a;
    win.push_back(v);
    if (win.size() > DEPTH) void'(win.pop_front());
    if (win.size() == DEPTH) begin
      s = 0;
      foreach (win[i]) s += win[i];
      a = s / DEPTH;
      if (a < NEAR) alarm_m = 1'b1;
      else if (a >= CLR) alarm_m = 1'b0;
      expq.push_back('{avg: a, alm: alarm_m, cyc: cyc + 2});
    end
  endfunction

  // All driver tasks start and end at posedge + 1
  task automatic send(input int v);
    dist_in    = 12'(v);
    dist_valid = 1'b1;
    if (is_outlier(v)) begin
      if (rej_m < 255) rej_m++;
    end else begin
      model_accept(v);
    end
    @(posedge clk);
    #1;
    dist_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_flush(input bit with_sample, input int v);
    flush      = 1'b1;
    dist_valid = with_sample;
    dist_in    = 12'(v);
    win.delete();
    @(posedge clk);
    #1;
    flush      = 1'b0;
    dist_valid = 1'b0;
  endtask

  // Monitor: every avg_valid must match the oldest outstanding expectation
  exp_t e;
  always @(negedge clk) begin
    if (avg_valid) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_avg_valid actual avg_out=%0d required no strobe (t=%0t)",
                 avg_out, $time);
      end else begin
        e = expq.pop_front();
        check("avg_out", int'(avg_out), e.avg);
        check("alarm_at_strobe", int'(alarm), int'(e.alm));
        check("strobe_cycle", cyc, e.cyc);
        check("filled_at_strobe", int'(filled), 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int r;
    rst        = 1'b1;
    dist_in    = '0;
    dist_valid = 1'b0;
    flush      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_avg_out", int'(avg_out), 0);
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_alarm", int'(alarm), 0);
    check("rst_filled", int'(filled), 0);
    check("rst_reject_cnt", int'(reject_cnt), 0);
    @(posedge clk);
    #1;

    // Fill window
    send(100); idle(3);
    send(200); idle(3);
    send(300);
    check("filled_before_4th", int'(filled), 0);
    idle(3);
    send(400);
    check("filled_after_4th", int'(filled), 1);
    idle(1);
    check("fill_avg", int'(avg_out), 250);
    idle(2);

    // Slide window
    send(800);
    idle(1);
    check("slide_avg", int'(avg_out), 425);
    idle(2);
    repeat (4) send(10);
    idle(1);
    check("b2b_avg", int'(avg_out), 10);
    idle(2);

    // Hysteresis
    repeat (4) send(20);
    idle(3);
    check("alarm_20s", int'(alarm), 1);
    repeat (4) send(34);
    idle(3);
    check("alarm_34s", int'(alarm), 1);
    repeat (3) send(35);
    idle(3);
    check("alarm_three_35s", int'(alarm), 1);
    send(35);
    idle(3);
    check("alarm_released", int'(alarm), 0);

    // Flush with the second sample of a fill
    do_flush(1'b0, 0);
    send(60);
    do_flush(1'b1, 77);
    check("flush_filled", int'(filled), 0);
    check("flush_avg_hold", int'(avg_out), 35);
    idle(3);
    repeat (4) send(50);
    idle(1);
    check("post_flush_avg", int'(avg_out), 50);
    idle(2);

    // Reset with a sample in stage 2
    repeat (4) send(10);
    idle(3);
    check("alarm_before_rst", int'(alarm), 1);
    send(123);
    rst = 1'b1;
    expq.delete();
    win.delete();
    alarm_m = 1'b0;
    rej_m   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_avg_valid", int'(avg_valid), 0);
    check("mid_rst_avg_out", int'(avg_out), 0);
    check("mid_rst_alarm", int'(alarm), 0);
    check("mid_rst_filled", int'(filled), 0);
    @(posedge clk);
    #1;
    send(7); send(8); send(9);
    check("refill_filled", int'(filled), 0);
    send(12);
    idle(3);

`ifdef RANGE_FILTER_OUTLIER_EN
    send(0);
    send(4000);
    idle(3);
    check("reject_two", int'(reject_cnt), 2);
    send(40);
    idle(3);
    repeat (300) send(0);
    idle(1);
    check("reject_sat", int'(reject_cnt), 255);
`endif

    // Randomized traffic, flushes only with an idle pipeline
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        idle(3);
        do_flush(1'($urandom_range(0, 1)), $urandom_range(1, 400));
      end else begin
        if (r == 1) v = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(401, 4095);
        else if (r < 10) v = $urandom_range(20, 45);
        else v = $urandom_range(1, 400);
        send(v);
      end
      idle($urandom_range(0, 2));
    end

    idle(5);
    check("queue_drained", expq.size(), 0);
    check("reject_cnt_final", int'(reject_cnt), rej_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
